// File: rtl/ntt_pointwise_mac.sv
// Streaming pointwise modular multiply / multiply-accumulate for NTT-domain polynomials.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, cfg_mode,      job request (IDLE only); mode 0=MUL 1=MAC; K pairs (0 means 1)
//   cfg_count
//   s_valid/s_ready,      input beat handshake; LANES coefficients of A and B per beat
//   s_a, s_b
//   m_valid/m_ready,      output beat handshake; C coefficients, m_last on final beat of a poly
//   m_data, m_last
//   busy, done            busy outside IDLE; done pulses once when the job has drained
module ntt_pointwise_mac #(
  parameter int unsigned N              = 256,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned Q              = 8380417,
  parameter int unsigned LANES          = 4,
  parameter int unsigned MULT_LATENCY   = 3,
  parameter int unsigned REDUCTION_TYPE = 1,
  parameter int unsigned MAX_K          = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           cfg_mode,
  input  logic [$clog2(MAX_K+1)-1:0]     cfg_count,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [LANES*WIDTH-1:0]         s_a,
  input  logic [LANES*WIDTH-1:0]         s_b,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [LANES*WIDTH-1:0]         m_data,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned BEATS = N / LANES;
  localparam int unsigned BW    = $clog2(BEATS);
  localparam int unsigned KW    = $clog2(MAX_K + 1);
  localparam int unsigned DW    = LANES * WIDTH;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned QB    = $clog2(Q);
  localparam int unsigned LS    = MULT_LATENCY - 1;
  localparam logic [PW-1:0]    QP = PW'(Q);
  localparam logic [WIDTH:0]   QS = (WIDTH+1)'(Q);
  localparam logic [127:0]     MU = (128'd1 << (2 * QB)) / 128'(Q);

  // -Q^-1 mod 2^WIDTH by Newton iteration (q*q == 1 mod 8 seeds 3 correct bits)
  function automatic logic [WIDTH-1:0] calc_qninv(input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] inv;
    inv = q;
    for (int i = 0; i < 6; i++) inv = inv * (WIDTH'(2) - q * inv);
    return WIDTH'(0) - inv;
  endfunction

  localparam logic [WIDTH-1:0] QNINV = calc_qninv(WIDTH'(Q));

  // Reduce a full product t < Q^2 to [0,Q-1] (Montgomery returns t*2^-WIDTH mod Q)
  function automatic logic [WIDTH-1:0] mod_reduce(input logic [PW-1:0] t);
    logic [127:0]     wide;
    logic [PW-1:0]    r;
    logic [PW:0]      u;
    logic [WIDTH-1:0] m;
    wide = '0;
    r    = '0;
    u    = '0;
    m    = '0;
    if (REDUCTION_TYPE == 0) begin
      r = t % QP;
    end else if (REDUCTION_TYPE == 1) begin
      // Barrett estimate is at most 2 below the true quotient
      wide = (128'(t) * MU) >> (2 * QB);
      r    = t - PW'(wide) * QP;
      if (r >= QP) r = r - QP;
      if (r >= QP) r = r - QP;
    end else begin
      m = t[WIDTH-1:0] * QNINV;
      u = ((PW+1)'(t) + (PW+1)'(PW'(m) * QP)) >> WIDTH;
      r = PW'(u);
      if (r >= QP) r = r - QP;
    end
    return WIDTH'(r);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [KW-1:0]     k_q, k_d, kmax_q, kmax_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic              m_valid_q, m_last_q;
  logic [DW-1:0]     m_data_q;

  logic [DW-1:0]     p_q     [MULT_LATENCY];
  logic              v_q     [MULT_LATENCY];
  logic [BW-1:0]     pbeat_q [MULT_LATENCY];
  logic              zacc_q  [MULT_LATENCY];
  logic              emit_q  [MULT_LATENCY];
  logic              last_q  [MULT_LATENCY];
  logic [DW-1:0]     acc_q   [BEATS];

  logic              stall, en, accept, pipe_busy;
  logic [DW-1:0]     prod_red, acc_rd, sum_red;
  logic              in_zacc, in_emit, in_last;

  assign stall   = m_valid_q && !m_ready;
  assign en      = !stall;
  assign s_ready = (state_q == S_RUN) && !stall;
  assign accept  = s_valid && s_ready;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

  // Per-beat control carried alongside the products
  assign in_zacc = !mode_q || (k_q == '0);
  assign in_emit = !mode_q || (k_q == kmax_q);
  assign in_last = in_emit && (beat_q == BW'(BEATS - 1));

  // Lane multipliers and reduction feeding the first pipeline register
  always_comb begin
    prod_red = '0;
    for (int j = 0; j < LANES; j++)
      prod_red[j*WIDTH +: WIDTH] =
        mod_reduce(PW'(s_a[j*WIDTH +: WIDTH]) * PW'(s_b[j*WIDTH +: WIDTH]));
  end

  // Add/writeback stage: accumulate onto ACC unless this is the first pair or MUL
  always_comb begin
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   s;
    acc_rd  = acc_q[pbeat_q[LS]];
    sum_red = '0;
    acc     = '0;
    s       = '0;
    for (int j = 0; j < LANES; j++) begin
      acc = zacc_q[LS] ? '0 : acc_rd[j*WIDTH +: WIDTH];
      s   = {1'b0, acc} + {1'b0, p_q[LS][j*WIDTH +: WIDTH]};
      sum_red[j*WIDTH +: WIDTH] = (s >= QS) ? WIDTH'(s - QS) : WIDTH'(s);
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < MULT_LATENCY; i++) pipe_busy = pipe_busy | v_q[i];
  end

  // Next-state logic: job sequencing and beat/pair counters
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    k_d     = k_q;
    kmax_d  = kmax_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          beat_d  = '0;
          k_d     = '0;
          mode_d  = cfg_mode;
          kmax_d  = (cfg_count == '0) ? '0 : KW'(cfg_count - KW'(1));
        end
      end
      S_RUN: begin
        if (accept) begin
          if (beat_q == BW'(BEATS - 1)) begin
            beat_d = '0;
            k_d    = KW'(k_q + KW'(1));
            if (k_q == kmax_q) state_d = S_DRAIN;
          end else begin
            beat_d = BW'(beat_q + BW'(1));
          end
        end
      end
      S_DRAIN: begin
        if (!pipe_busy && (!m_valid_q || m_ready)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      k_q     <= '0;
      kmax_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      k_q     <= k_d;
      kmax_q  <= kmax_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Pipeline control and output registers; a stall freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MULT_LATENCY; i++) begin
        v_q[i]     <= 1'b0;
        pbeat_q[i] <= '0;
        zacc_q[i]  <= 1'b0;
        emit_q[i]  <= 1'b0;
        last_q[i]  <= 1'b0;
      end
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (en) begin
      v_q[0]     <= accept;
      pbeat_q[0] <= beat_q;
      zacc_q[0]  <= in_zacc;
      emit_q[0]  <= in_emit;
      last_q[0]  <= in_last;
      for (int i = 1; i < MULT_LATENCY; i++) begin
        v_q[i]     <= v_q[i-1];
        pbeat_q[i] <= pbeat_q[i-1];
        zacc_q[i]  <= zacc_q[i-1];
        emit_q[i]  <= emit_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
      m_valid_q <= v_q[LS] && emit_q[LS];
      m_last_q  <= v_q[LS] && emit_q[LS] && last_q[LS];
      if (v_q[LS] && emit_q[LS]) m_data_q <= sum_red;
    end
  end

  // Product datapath and accumulator storage (contents need no reset)
  always_ff @(posedge clk) begin
    if (en) begin
      p_q[0] <= prod_red;
      for (int i = 1; i < MULT_LATENCY; i++) p_q[i] <= p_q[i-1];
      if (v_q[LS] && !emit_q[LS]) acc_q[pbeat_q[LS]] <= sum_red;
    end
  end

endmodule
